// File: rtl/pc_ctrl_if.sv
// Pipeline-to-PC-controller signal bundle: redirect/hazard requests in,
// PC/IF-ID control and event counters out.
interface pc_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             branch_taken;
  logic [31:0]      branch_target;
  logic             jump;
  logic [31:0]      jump_target;
  logic             load_use_hazard;
  logic             imem_ready;
  logic             PCWrite;
  logic             PCSrc;
  logic [31:0]      PCMux;
  logic             IFID_write;
  logic             IFID_flush;
  logic             IDEX_flush;
  logic [CNT_W-1:0] redirect_count;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output branch_taken, branch_target, jump, jump_target,
           load_use_hazard, imem_ready,
    input  PCWrite, PCSrc, PCMux, IFID_write, IFID_flush, IDEX_flush,
           redirect_count, stall_count
  );

  modport slave (
    input  branch_taken, branch_target, jump, jump_target,
           load_use_hazard, imem_ready,
    output PCWrite, PCSrc, PCMux, IFID_write, IFID_flush, IDEX_flush,
           redirect_count, stall_count
  );
endinterface

// File: rtl/pc_ctrl.sv
// PC sequencing controller: boot hold-off, prioritised branch/jump/hazard
// handling, deferred redirects while imem is busy, and event counters.
module pc_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned BOOT_CYCLES = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  pc_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_REDIR
  } state_e;

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       boot_cnt_q, boot_cnt_d;
  logic [31:0]      pend_target_q, pend_target_d;
  logic [CNT_W-1:0] redirect_count_q, redirect_count_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic             pc_write;
  logic             pc_src;
  logic [31:0]      pc_mux;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_flush;

  always_comb begin
    state_d       = state_q;
    boot_cnt_d    = boot_cnt_q;
    pend_target_d = pend_target_q;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    pc_mux        = '0;
    ifid_write    = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;

    unique case (state_q)
      S_BOOT: begin
        ifid_write = 1'b0;
        if (boot_cnt_q == BOOT_LAST) begin
          state_d = S_RUN;
        end else begin
          boot_cnt_d = boot_cnt_q + 4'd1;
        end
      end

      S_RUN: begin
        if (bus.imem_ready) begin
          if (bus.branch_taken) begin
            pc_write   = 1'b1;
            pc_src     = 1'b1;
            pc_mux     = bus.branch_target;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (bus.jump) begin
            pc_write   = 1'b1;
            pc_src     = 1'b1;
            pc_mux     = bus.jump_target;
            ifid_flush = 1'b1;
          end else if (bus.load_use_hazard) begin
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end else begin
            pc_write = 1'b1;
          end
        end else begin
          // Fetch blocked: squash now, remember the target, apply it later.
          ifid_write = 1'b0;
          if (bus.branch_taken) begin
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
            pend_target_d = bus.branch_target;
            state_d       = S_REDIR;
          end else if (bus.jump) begin
            ifid_flush    = 1'b1;
            pend_target_d = bus.jump_target;
            state_d       = S_REDIR;
          end
        end
      end

      S_REDIR: begin
        if (bus.imem_ready) begin
          pc_write   = 1'b1;
          pc_src     = 1'b1;
          ifid_flush = 1'b1;
          state_d    = S_RUN;
          if (bus.branch_taken) begin
            pc_mux     = bus.branch_target;
            idex_flush = 1'b1;
          end else begin
            pc_mux = pend_target_q;
          end
        end else begin
          // An older (EX) branch supersedes the pending target; jumps are younger.
          ifid_write = 1'b0;
          if (bus.branch_taken) begin
            pend_target_d = bus.branch_target;
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase

    redirect_count_d = redirect_count_q;
    if (pc_write && pc_src) begin
      redirect_count_d = redirect_count_q + CNT_W'(1);
    end

    stall_count_d = stall_count_q;
    if ((state_q != S_BOOT) && !pc_write && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_BOOT;
      boot_cnt_q       <= '0;
      pend_target_q    <= '0;
      redirect_count_q <= '0;
      stall_count_q    <= '0;
    end else begin
      state_q          <= state_d;
      boot_cnt_q       <= boot_cnt_d;
      pend_target_q    <= pend_target_d;
      redirect_count_q <= redirect_count_d;
      stall_count_q    <= stall_count_d;
    end
  end

  assign bus.PCWrite        = pc_write;
  assign bus.PCSrc          = pc_src;
  assign bus.PCMux          = pc_mux;
  assign bus.IFID_write     = ifid_write;
  assign bus.IFID_flush     = ifid_flush;
  assign bus.IDEX_flush     = idex_flush;
  assign bus.redirect_count = redirect_count_q;
  assign bus.stall_count    = stall_count_q;

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter: CNT_W, default 16, width of the redirect and stall event counters.
REQ-002 Parameter: BOOT_CYCLES, default 2, cycles after reset release before the PC may advance (range 1..15).
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock shared with the PC register.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 branch_taken  in  1  EX-stage resolved taken branch.
REQ-007 branch_target  in  32  EX-stage branch target.
REQ-008 jump  in  1  ID-stage unconditional jump.
REQ-009 jump_target  in  32  ID-stage jump target.
REQ-010 load_use_hazard  in  1  ID-stage load-use hazard request.
REQ-011 imem_ready  in  1  instruction memory can accept a fetch this cycle.
REQ-012 PCWrite  out  1  PC register write enable.
REQ-013 PCSrc  out  1  1 = load PCMux; 0 = PC+4.
REQ-014 PCMux  out  32  redirect target.
REQ-015 IFID_write  out  1  IF/ID register write enable.
REQ-016 IFID_flush  out  1  squash IF/ID contents.
REQ-017 IDEX_flush  out  1  insert a bubble into ID/EX.
REQ-018 redirect_count  out  CNT_W  number of applied redirects, wraps.
REQ-019 stall_count  out  CNT_W  number of frozen cycles, saturates at all-ones.

Function
REQ-020 The FSM SHALL have three states: BOOT, RUN and REDIR.
REQ-021 All outputs except the counters SHALL be combinational from state, pend_target and the inputs; the counters and state SHALL be registered.
REQ-022 Default outputs: PCWrite=0, PCSrc=0, PCMux=0, IFID_write=1, both flushes=0.
REQ-023 BOOT behaviour:
- PCWrite=0, IFID_write=0.
- Redirect and hazard inputs are ignored.
- The FSM moves to RUN after BOOT_CYCLES clocks.
REQ-024 RUN with imem_ready=1, decided by fixed priority:
- branch_taken: PCWrite=1, PCSrc=1, PCMux=branch_target, IFID_flush=1, IDEX_flush=1.
- else jump: PCWrite=1, PCSrc=1, PCMux=jump_target, IFID_flush=1.
- else load_use_hazard: PCWrite=0, IFID_write=0, IDEX_flush=1.
- else: PCWrite=1, PCSrc=0.
REQ-025 A taken branch SHALL override a same-cycle jump and load_use_hazard; the younger requests are discarded.
REQ-026 RUN with imem_ready=0:
- PCWrite=0, IFID_write=0.
- If branch_taken or jump is asserted, the flushes SHALL be driven as in REQ-024, the winning target latched into pend_target, and the FSM moves to REDIR.
REQ-027 REDIR with imem_ready=0:
- PCWrite=0, IFID_write=0.
- branch_taken SHALL overwrite pend_target and assert both flushes; jump is ignored.
REQ-028 REDIR with imem_ready=1:
- PCWrite=1, PCSrc=1, IFID_flush=1, and the FSM returns to RUN.
- PCMux=branch_target if branch_taken is asserted (also asserts IDEX_flush); otherwise PCMux=pend_target.
REQ-029 redirect_count SHALL increment on every cycle with PCWrite=1 and PCSrc=1, wrapping modulo 2^CNT_W.
REQ-030 stall_count SHALL increment on every non-BOOT cycle with PCWrite=0 and SHALL hold at 2^CNT_W-1.
REQ-031 Counter increments SHALL take effect on the next rising edge (1-cycle latency).
REQ-032 pend_target SHALL be observable only via PCMux while in REDIR.

Reset
REQ-033 On rst_n=0, regardless of clk, the block SHALL immediately:
- enter BOOT;
- clear pend_target and both counters to 0;
- drive the BOOT outputs (PCWrite=0, PCSrc=0, PCMux=0, IFID_write=0, both flushes=0).
REQ-034 Reset asserted in REDIR SHALL discard the pending redirect.
REQ-035 The BOOT count SHALL restart on each reset release.

Verification
REQ-036 Release reset with imem_ready=1 and no requests -> PCWrite=0 for exactly 2 cycles, then PCWrite=1, PCSrc=0 every cycle.
REQ-037 In RUN, assert branch_taken=1, branch_target=0x100, jump=1, jump_target=0x200 -> PCMux=0x100, both flushes=1, redirect_count +1.
REQ-038 In RUN, hold load_use_hazard=1 for 1 cycle -> PCWrite=0, IFID_write=0, IDEX_flush=1, stall_count +1, then normal advance.
REQ-039 Drive imem_ready=0 with jump=1, jump_target=0x40, then 3 idle cycles, then imem_ready=1 -> REDIR held for 4 cycles; on release PCSrc=1, PCMux=0x40; stall_count=4.
REQ-040 In REDIR (pending 0x40), assert branch_taken with target 0x80 while imem_ready=0 -> PCMux=0x80 on release.
REQ-041 Force stall_count to all-ones via stalls -> it stays at 0xFFFF; assert rst_n=0 mid-REDIR -> outputs reset immediately and no redirect occurs after release.
